// File: rtl/serial_link_pkg.sv
// Shared types and constants for the serial link: FSM state encoding and
// default frame width used by the byte serializer and its helpers.
package serial_link_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while run is high and flags
// the terminal count; held at zero whenever run is low.
module bit_tick_gen
    import serial_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tick
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    // NOTE: flops use non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (!run || cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial feeder: accepts a word on valid/ready and emits it
// LSB-first with one shift strobe per bit, followed by an idle gap.
module byte_serializer
    import serial_link_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEFAULT,
    parameter int CLKS_PER_BIT = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_data,
    output logic              ser_en,
    output logic              busy,
    output logic              frame_done
);

    localparam int BW = cnt_width(DATA_W);
    localparam int GW = cnt_width(GAP_CYCLES);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    ser_state_e        state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [BW-1:0]     bit_cnt_q;
    logic [GW-1:0]     gap_cnt_q;
    logic              tick;

    bit_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .run    (state_q == SHIFT),
        .tick   (tick)
    );

    // NOTE: shreg is cleared on reset as well, so an abandoned frame leaves
    // no stale bits behind for the next accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shreg_q   <= in_data;
                        bit_cnt_q <= '0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        shreg_q   <= {1'b0, shreg_q[DATA_W-1:1]};
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_q <= '0;
                            gap_cnt_q <= '0;
                            state_q   <= (GAP_CYCLES == 0) ? IDLE : GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; no input reaches an output.
    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign ser_en     = tick && (state_q == SHIFT);
    assign ser_data   = (state_q == SHIFT) && shreg_q[0];
    assign frame_done = ser_en && (bit_cnt_q == BIT_LAST);

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: default-paced instance (d=0) and a fast
// instance with one clock per bit and no gap (d=1), scoreboard-checked.
module tb_byte_serializer;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] in_data [2];
    logic [1:0] in_valid;
    logic [1:0] in_ready, ser_data, ser_en, busy, frame_done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc [2];
    int idx [2];
    int strobes [2];
    int dones [2];
    int accepts [2];
    logic [7:0] model [2];

    logic       exp_bit_a [$];
    logic       exp_bit_b [$];
    logic [7:0] exp_byte_a [$];
    logic [7:0] exp_byte_b [$];

    typedef struct {
        int         d;
        logic [7:0] data;
        logic [7:0] exp_byte;
        int         exp_low;
    } vec_t;

    byte_serializer #(.DATA_W(8), .CLKS_PER_BIT(4), .GAP_CYCLES(2)) u_dut_slow (
        .clk(clk), .reset_n(reset_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .ser_data(ser_data[0]), .ser_en(ser_en[0]),
        .busy(busy[0]), .frame_done(frame_done[0])
    );

    byte_serializer #(.DATA_W(8), .CLKS_PER_BIT(1), .GAP_CYCLES(0)) u_dut_fast (
        .clk(clk), .reset_n(reset_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .ser_data(ser_data[1]), .ser_en(ser_en[1]),
        .busy(busy[1]), .frame_done(frame_done[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int cpb(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic void push_frame(input int d, input logic [7:0] v);
        for (int i = 0; i < W; i++) begin
            if (d == 0) exp_bit_a.push_back(v[i]);
            else        exp_bit_b.push_back(v[i]);
        end
        if (d == 0) exp_byte_a.push_back(v);
        else        exp_byte_b.push_back(v);
    endfunction

    task automatic pop_bit(input int d, output logic b, output logic ok);
        ok = 1'b0;
        b  = 1'b0;
        if (d == 0) begin
            if (exp_bit_a.size() > 0) begin b = exp_bit_a.pop_front(); ok = 1'b1; end
        end else if (exp_bit_b.size() > 0) begin
            b = exp_bit_b.pop_front(); ok = 1'b1;
        end
    endtask

    task automatic pop_byte(input int d, output logic [7:0] v, output logic ok);
        ok = 1'b0;
        v  = 8'h00;
        if (d == 0) begin
            if (exp_byte_a.size() > 0) begin v = exp_byte_a.pop_front(); ok = 1'b1; end
        end else if (exp_byte_b.size() > 0) begin
            v = exp_byte_b.pop_front(); ok = 1'b1;
        end
    endtask

    // Downstream model and scoreboard, sampled mid-cycle.
    logic       mon_bit, mon_ok;
    logic [7:0] mon_byte;
    always @(negedge clk) begin
        if (reset_n) begin
            for (int d = 0; d < 2; d++) begin
                if (in_ready[d]) check("idle_ser_data_low", int'(ser_data[d]), 0);
                if (ser_en[d]) begin
                    pop_bit(d, mon_bit, mon_ok);
                    check("strobe_expected", int'(mon_ok), 1);
                    if (mon_ok) check("strobe_bit", int'(ser_data[d]), int'(mon_bit));
                    check("strobe_cycle", cyc - acc[d], (idx[d] + 1) * cpb(d));
                    model[d]   <= {ser_data[d], model[d][7:1]};
                    idx[d]     <= idx[d] + 1;
                    strobes[d] <= strobes[d] + 1;
                end
                if (frame_done[d]) begin
                    check("done_with_strobe", int'(ser_en[d]), 1);
                    check("done_cycle", cyc - acc[d], W * cpb(d));
                    pop_byte(d, mon_byte, mon_ok);
                    check("done_expected", int'(mon_ok), 1);
                    if (mon_ok) check("done_model", int'({ser_data[d], model[d][7:1]}), int'(mon_byte));
                    dones[d] <= dones[d] + 1;
                end
                if (in_valid[d] && in_ready[d]) begin
                    acc[d]     <= cyc;
                    idx[d]     <= 0;
                    accepts[d] <= accepts[d] + 1;
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic wait_accept(input int d, input logic [7:0] v, input logic [7:0] exp_byte,
                               output int low);
        low = 0;
        in_data[d]  = v;
        in_valid[d] = 1'b1;
        @(negedge clk);
        while (!in_ready[d] && low < 200) begin
            low++;
            @(negedge clk);
        end
        if (!in_ready[d]) begin
            check("accept_timeout", 0, 1);
        end else begin
            push_frame(d, exp_byte);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready[d] && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("idle_reached", int'(in_ready[d]), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [5];
        int   low, low2, s0, f0, a0;

        vecs[0] = '{d: 0, data: 8'hA5, exp_byte: 8'hA5, exp_low: 0};
        vecs[1] = '{d: 0, data: 8'h01, exp_byte: 8'h01, exp_low: 0};
        vecs[2] = '{d: 0, data: 8'hFE, exp_byte: 8'hFE, exp_low: 0};
        vecs[3] = '{d: 1, data: 8'hF0, exp_byte: 8'hF0, exp_low: 0};
        vecs[4] = '{d: 1, data: 8'h6B, exp_byte: 8'h6B, exp_low: 0};

        for (int d = 0; d < 2; d++) begin
            in_data[d] = 8'h00; in_valid[d] = 1'b0;
            acc[d] = 0; idx[d] = 0; strobes[d] = 0; dones[d] = 0; accepts[d] = 0;
            model[d] = 8'h00;
        end

        // Power-on reset: outputs settle asynchronously.
        #1 reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("por_in_ready", int'(in_ready[d]), 1);
            check("por_busy", int'(busy[d]), 0);
            check("por_ser_en", int'(ser_en[d]), 0);
            check("por_ser_data", int'(ser_data[d]), 0);
            check("por_frame_done", int'(frame_done[d]), 0);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single frames from the vector table.
        foreach (vecs[i]) begin
            s0 = strobes[vecs[i].d];
            f0 = dones[vecs[i].d];
            wait_accept(vecs[i].d, vecs[i].data, vecs[i].exp_byte, low);
            in_valid[vecs[i].d] = 1'b0;
            check("vec_accept_wait", low, vecs[i].exp_low);
            check("vec_busy", int'(busy[vecs[i].d]), 1);
            wait_idle(vecs[i].d);
            check("vec_strobe_count", strobes[vecs[i].d] - s0, W);
            check("vec_done_count", dones[vecs[i].d] - f0, 1);
        end

        // Back-to-back with valid held: ready low for cycles 1..34.
        f0 = dones[0];
        wait_accept(0, 8'h3C, 8'h3C, low);
        wait_accept(0, 8'hC3, 8'hC3, low2);
        in_valid[0] = 1'b0;
        check("b2b_first_wait", low, 0);
        check("b2b_ready_low_cycles", low2, 34);
        wait_idle(0);
        check("b2b_done_count", dones[0] - f0, 2);

        // Fast instance back-to-back: period of 9 cycles.
        f0 = dones[1];
        wait_accept(1, 8'hF0, 8'hF0, low);
        wait_accept(1, 8'h0F, 8'h0F, low2);
        in_valid[1] = 1'b0;
        check("fast_ready_low_cycles", low2, 8);
        wait_idle(1);
        check("fast_done_count", dones[1] - f0, 2);

        // Input changes after accept must not disturb the frame.
        s0 = strobes[0];
        a0 = accepts[0];
        wait_accept(0, 8'h00, 8'h00, low);
        in_data[0] = 8'hFF;
        check("stab_ready_low", int'(in_ready[0]), 0);
        for (int i = 0; i < 30; i++) begin
            in_valid[0] = (i % 2 == 0);
            @(posedge clk);
            #1;
        end
        in_valid[0] = 1'b0;
        wait_idle(0);
        repeat (5) @(posedge clk);
        #1;
        check("stab_strobe_count", strobes[0] - s0, W);
        check("stab_accept_count", accepts[0] - a0, 1);

        // Reset in cycle 10 of a 0x55 frame.
        wait_accept(0, 8'h55, 8'h55, low);
        in_valid[0] = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("mid_pre_reset_bit", int'(ser_data[0]), 1);
        check("mid_pre_reset_busy", int'(busy[0]), 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_in_ready", int'(in_ready[0]), 1);
        check("mid_rst_busy", int'(busy[0]), 0);
        check("mid_rst_ser_en", int'(ser_en[0]), 0);
        check("mid_rst_ser_data", int'(ser_data[0]), 0);
        check("mid_rst_frame_done", int'(frame_done[0]), 0);
        exp_bit_a.delete();
        exp_byte_a.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        s0 = strobes[0];
        repeat (40) @(posedge clk);
        #1;
        check("post_reset_no_strobe", strobes[0] - s0, 0);
        check("post_reset_idle", int'(in_ready[0]), 1);
        f0 = dones[0];
        wait_accept(0, 8'h81, 8'h81, low);
        in_valid[0] = 1'b0;
        wait_idle(0);
        check("post_reset_strobes", strobes[0] - s0, W);
        check("post_reset_done", dones[0] - f0, 1);

        check("scoreboard_bits_drained", exp_bit_a.size() + exp_bit_b.size(), 0);
        check("scoreboard_bytes_drained", exp_byte_a.size() + exp_byte_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
